stream_feeder: RTL and testbench

STREAM_FEEDER -- requirements
Module: stream_feeder

---
 rtl/stream_feeder.sv | 112 +++++++++++
 tb/tb_stream_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_feeder.sv
// stream_feeder: FIFO-buffered host byte stream framed as sod/data_out+en_out/eod with post-packet flush (in: clk, rst, s_data, s_valid, s_last; out: s_ready, sod, data_out, en_out, eod, busy; pkt_count only with STREAM_FEEDER_PKTCNT_EN)
module stream_feeder #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FLUSH_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        sod,
  output logic [7:0]  data_out,
  output logic        en_out,
  output logic        eod,
  output logic        busy
`ifdef STREAM_FEEDER_PKTCNT_EN
  ,
  output logic [15:0] pkt_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SOD, DATA, EOD, FLUSH} state_t;
  state_t state, state_d;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] fcnt, fcnt_d;
  logic done, done_d, push, pop, empty, fl_end, sod_d, en_d, eod_d;
  logic [7:0] data_d;
  assign empty   = count == '0;
  assign s_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push    = s_valid && s_ready;
  assign fl_end  = fcnt == CW'(FLUSH_CYCLES - 1);
  always_comb begin
    state_d = state;
    fcnt_d  = fcnt;
    pop     = 1'b0;
    sod_d   = 1'b0;
    eod_d   = 1'b0;
    case (state)
      IDLE: begin
        state_d = empty ? IDLE : SOD;
        sod_d   = !empty;
      end
      SOD: begin
        state_d = DATA;
        pop     = !empty;
      end
      DATA: begin
        state_d = done ? EOD : DATA;
        eod_d   = done;
        pop     = !done && !empty;
      end
      EOD: begin
        state_d = FLUSH;
        fcnt_d  = '0;
      end
      FLUSH: begin
        state_d = fl_end ? (empty ? IDLE : SOD) : FLUSH;
        sod_d   = fl_end && !empty;
        fcnt_d  = fl_end ? '0 : fcnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    en_d   = pop;
    data_d = pop ? mem[rd_ptr][7:0] : data_out;
    done_d = pop ? mem[rd_ptr][8] : done && !eod_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fcnt     <= '0;
      done     <= 1'b0;
      sod      <= 1'b0;
      en_out   <= 1'b0;
      eod      <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_d;
      fcnt     <= fcnt_d;
      done     <= done_d;
      sod      <= sod_d;
      en_out   <= en_d;
      eod      <= eod_d;
      busy     <= state_d != IDLE;
      data_out <= data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {s_last, s_data};
  end
`ifdef STREAM_FEEDER_PKTCNT_EN
  always_ff @(posedge clk) begin
    if (rst) pkt_count <= '0;
    else if (eod_d) pkt_count <= pkt_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_stream_feeder.sv
// tb_stream_feeder: randomized and directed bench for stream_feeder against a packet-level reference model
module tb_stream_feeder;
  localparam int DEPTH = 16;
  localparam int FLUSH = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic s_ready, sod, en_out, eod, busy;
  logic [7:0] data_out;
`ifdef STREAM_FEEDER_PKTCNT_EN
  logic [15:0] pkt_count;
`endif
  stream_feeder #(.FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .sod(sod), .data_out(data_out), .en_out(en_out), .eod(eod), .busy(busy)
`ifdef STREAM_FEEDER_PKTCNT_EN
    , .pkt_count(pkt_count)
`endif
  );
  always #5 clk = ~clk;
  int pass_n = 0, total_n = 0, fail_n = 0;
  int cyc = 0, last_eod = -100, n_eod = 0, acc_n = 0, en_n = 0, t = 0;
  logic [8:0] exp_q [$];
  int sod_c [$], en_c [$], eod_c [$];
  logic in_pkt = 1'b0, exp_eod = 1'b0, last_acc = 1'b0;
  logic [7:0] prev_data = '0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  task automatic tick();
    logic r, nxt_eod;
    logic [8:0] e;
    r = rst;
    last_acc = s_valid && s_ready && !rst;
    if (last_acc) begin
      exp_q.push_back({s_last, s_data});
      acc_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      exp_q.delete();
      in_pkt = 1'b0; exp_eod = 1'b0; prev_data = '0;
      last_eod = -100; n_eod = 0; acc_n = 0; en_n = 0;
      check("rst_sod", sod, 0);
      check("rst_en", en_out, 0);
      check("rst_eod", eod, 0);
      check("rst_busy", busy, 0);
      check("rst_data", data_out, 0);
      check("rst_ready", s_ready, 1);
`ifdef STREAM_FEEDER_PKTCNT_EN
      check("rst_pkt_count", pkt_count, 0);
`endif
    end else begin
      check("exclusive", 32'(sod) + 32'(en_out) + 32'(eod) <= 1, 1);
      check("eod_timing", eod, exp_eod);
      nxt_eod = 1'b0;
      if (en_out) begin
        check("byte_expected", exp_q.size() > 0, 1);
        check("en_in_pkt", in_pkt, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data", data_out, e[7:0]);
          nxt_eod = e[8];
        end
        en_n++;
        en_c.push_back(cyc);
      end else check("data_hold", data_out, prev_data);
      if (sod) begin
        check("sod_outside_pkt", in_pkt, 0);
        check("sod_gap", cyc - last_eod >= FLUSH + 1, 1);
        in_pkt = 1'b1;
        sod_c.push_back(cyc);
      end
      if (eod) begin
        in_pkt = 1'b0;
        n_eod++;
        last_eod = cyc;
        eod_c.push_back(cyc);
      end
      check("busy", busy, in_pkt || eod || (cyc - last_eod <= FLUSH));
      check("s_ready", s_ready, (acc_n - en_n) != DEPTH);
`ifdef STREAM_FEEDER_PKTCNT_EN
      check("pkt_count", pkt_count, n_eod & 32'hFFFF);
`endif
      prev_data = data_out;
      exp_eod = nxt_eod;
    end
  endtask
  task automatic push(input logic [7:0] d, input logic l);
    int w = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    do begin
      tick();
      w++;
    end while (!last_acc && w < 200);
    check("push_timeout", last_acc, 1);
  endtask
  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic run_until(input int c);
    s_valid = 1'b0;
    while (cyc < c) tick();
  endtask
  task automatic drain();
    int w = 0;
    s_valid = 1'b0;
    while ((exp_q.size() > 0 || busy) && w < 1000) begin
      tick();
      w++;
    end
    check("drain_timeout", exp_q.size() == 0 && !busy, 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic clear_logs();
    sod_c.delete(); en_c.delete(); eod_c.delete();
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
    push(8'h41, 1'b0);
    t = cyc;
    push(8'h42, 1'b0);
    push(8'h43, 1'b1);
    run_until(t + 12);
    check("t34_sod", qat(sod_c, 0), t + 1);
    check("t34_en0", qat(en_c, 0), t + 2);
    check("t34_en1", qat(en_c, 1), t + 3);
    check("t34_en2", qat(en_c, 2), t + 4);
    check("t34_eod", qat(eod_c, 0), t + 5);
    check("t34_busy_done", busy, 0);
    do_reset();
    clear_logs();
    push(8'h10, 1'b1);
    t = cyc;
    run_until(t + 12);
    check("t35_sod", qat(sod_c, 0), t + 1);
    check("t35_en", qat(en_c, 0), t + 2);
    check("t35_en_n", en_c.size(), 1);
    check("t35_eod", qat(eod_c, 0), t + 3);
`ifdef STREAM_FEEDER_PKTCNT_EN
    check("t35_pkt_count", pkt_count, 1);
`endif
    clear_logs();
    for (int i = 0; i < 20; i++) push(8'(8'h60 + i), i == 19);
    drain();
    check("t36_en_n", en_c.size(), 20);
    check("t36_contiguous", qat(en_c, 19) - qat(en_c, 0), 19);
    check("t36_eod_n", eod_c.size(), 1);
    clear_logs();
    push(8'h01, 1'b0);
    t = cyc;
    idle(3);
    push(8'h02, 1'b1);
    drain();
    check("t37_en0", qat(en_c, 0), t + 2);
    check("t37_en1", qat(en_c, 1), t + 5);
    check("t37_sod_n", sod_c.size(), 1);
    check("t37_eod_n", eod_c.size(), 1);
    clear_logs();
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b1);
    push(8'hB1, 1'b0);
    push(8'hB2, 1'b1);
    drain();
    check("t38_sod_n", sod_c.size(), 2);
    check("t38_gap", qat(sod_c, 1) - qat(eod_c, 0), FLUSH + 1);
    clear_logs();
    push(8'hC0, 1'b0);
    push(8'hC1, 1'b0);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hC2; s_last = 1'b0;
    tick();
    rst = 1'b0;
    idle(4);
    check("t39_no_eod", eod_c.size(), 0);
    clear_logs();
    push(8'h55, 1'b1);
    t = cyc;
    run_until(t + 12);
    check("t39_sod", qat(sod_c, 0), t + 1);
    check("t39_en", qat(en_c, 0), t + 2);
    check("t39_eod", qat(eod_c, 0), t + 3);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      push(8'($urandom), ($urandom_range(3) == 0) || i == 299);
    end
    drain();
    check("rand_all_out", en_n, acc_n);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
